// File: rtl/alu_serial_rx_if.sv
// Command handshake between the serial receiver (master) and the ALU core (slave).
interface alu_serial_rx_if;
    // valid/ready: a command transfers on a posedge where cmd_valid && cmd_ready are
    // both 1; the master holds cmd_valid and every cmd_* field stable until that edge.
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_crc4;
    logic [1:0]  cmd_status;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_crc4, cmd_status,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_crc4, cmd_status,
        output cmd_ready
    );
endinterface

// File: rtl/alu_serial_rx.sv
// Serial command receiver: 8 DATA + 1 CTL packets on sin -> one {A, B, op, crc4} command.
// Optional CRC-4 checking is enabled by defining ALU_RX_CRC_CHECK_EN.
module alu_serial_rx #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sin,
    alu_serial_rx_if.master cmd,
    output logic            overrun,
    output logic [1:0]      state_dbg
);
    typedef enum logic [1:0] {S_IDLE, S_TYPE, S_BITS, S_STOP} state_t;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_ERR_DATA  = 2'b01;
    localparam logic [1:0] ST_ERR_CRC   = 2'b10;
    localparam logic [1:0] ST_ERR_FRAME = 2'b11;
    localparam int GW = $clog2(TIMEOUT_CYC + 2);

    state_t        state;
    logic          armed;
    logic          pkt_ctl;
    logic [2:0]    bit_cnt;
    logic [3:0]    pkt_cnt;
    logic [7:0]    shreg;
    logic [63:0]   ab_buf;     // {B, A}: bytes shift in from the bottom, first byte ends on top
    logic [GW-1:0] gap_cnt;
    logic          full;
    logic          crc_bad;
    logic          timeout_hit;
    logic          done;
    logic [1:0]    done_status;
    logic [2:0]    done_op;
    logic [3:0]    done_crc;

    assign full      = (pkt_cnt == 4'd8);
    assign state_dbg = state;

`ifdef ALU_RX_CRC_CHECK_EN
    logic [3:0] crc;

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    assign crc_bad = (crc != shreg[3:0]);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        done        = 1'b0;
        done_status = ST_OK;
        done_op     = 3'd0;
        done_crc    = 4'd0;
        // A start bit seen on the same edge wins over the timeout.
        timeout_hit = (TIMEOUT_CYC != 0) && (state == S_IDLE) && (pkt_cnt != 4'd0) &&
                      !(armed && !sin) && (gap_cnt == GW'(TIMEOUT_CYC));
        if (timeout_hit) begin
            done        = 1'b1;
            done_status = ST_ERR_FRAME;
        end else if (state == S_STOP) begin
            if (!sin) begin
                done        = 1'b1;
                done_status = ST_ERR_FRAME;
            end else if (pkt_ctl) begin
                done        = 1'b1;
                done_op     = shreg[6:4];
                done_crc    = shreg[3:0];
                if (!full)        done_status = ST_ERR_DATA;
                else if (crc_bad) done_status = ST_ERR_CRC;
            end else if (full) begin
                done        = 1'b1;
                done_status = ST_ERR_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            armed   <= 1'b0;
            pkt_ctl <= 1'b0;
            bit_cnt <= 3'd0;
            pkt_cnt <= 4'd0;
            shreg   <= 8'd0;
            ab_buf  <= 64'd0;
            gap_cnt <= '0;
`ifdef ALU_RX_CRC_CHECK_EN
            crc     <= 4'd0;
`endif
        end else begin
            if (sin) armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (armed && !sin) begin
                        state   <= S_TYPE;
                        gap_cnt <= '0;
                    end else if (pkt_cnt != 4'd0 && TIMEOUT_CYC != 0) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_TYPE: begin
                    pkt_ctl <= sin;
                    bit_cnt <= 3'd7;
                    state   <= S_BITS;
                end
                S_BITS: begin
                    shreg <= {shreg[6:0], sin};
`ifdef ALU_RX_CRC_CHECK_EN
                    // CTL folds the constant 1 (in place of d[7]) and then op into the CRC.
                    if (!pkt_ctl && !full)                  crc <= crc_step(crc, sin);
                    else if (pkt_ctl && bit_cnt == 3'd7)    crc <= crc_step(crc, 1'b1);
                    else if (pkt_ctl && bit_cnt >= 3'd4)    crc <= crc_step(crc, sin);
`endif
                    if (bit_cnt == 3'd0) state <= S_STOP;
                    else                 bit_cnt <= bit_cnt - 3'd1;
                end
                S_STOP: begin
                    if (!sin) begin
                        armed <= 1'b0;
                    end else if (!pkt_ctl && !full) begin
                        ab_buf  <= {ab_buf[55:0], shreg};
                        pkt_cnt <= pkt_cnt + 4'd1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (done) begin
                pkt_cnt <= 4'd0;
                gap_cnt <= '0;
`ifdef ALU_RX_CRC_CHECK_EN
                crc     <= 4'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd.cmd_valid  <= 1'b0;
            cmd.cmd_a      <= 32'd0;
            cmd.cmd_b      <= 32'd0;
            cmd.cmd_op     <= 3'd0;
            cmd.cmd_crc4   <= 4'd0;
            cmd.cmd_status <= 2'd0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (cmd.cmd_valid && cmd.cmd_ready) cmd.cmd_valid <= 1'b0;
            if (done) begin
                if (!cmd.cmd_valid || cmd.cmd_ready) begin
                    cmd.cmd_valid  <= 1'b1;
                    cmd.cmd_a      <= full ? ab_buf[31:0]  : 32'd0;
                    cmd.cmd_b      <= full ? ab_buf[63:32] : 32'd0;
                    cmd.cmd_op     <= done_op;
                    cmd.cmd_crc4   <= done_crc;
                    cmd.cmd_status <= done_status;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule
